// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory-side request responder.
// Request mode encodings, responder FSM states and read-data source select.
package mem_responder_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } resp_state_e;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_RAM,
    SRC_CTR
  } data_src_e;

endpackage

// File: rtl/mem_bram_lanes.sv
// Purpose: four 8-bit synchronous RAM lanes with per-lane write enable (BRAM-inferable).
// Latency: one cycle read (rdata updates on the edge where re is high); writes commit on the edge.
// Backpressure: none; every access completes in one cycle.
module mem_bram_lanes #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [2**ADDR_W];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (we[i]) mem[waddr] <= wdata[8*i +: 8];
      if (re)    q <= mem[raddr];
    end

    assign rdata[8*i +: 8] = q;
  end

endmodule

// File: rtl/mem_responder.sv
// Purpose: memory end of the MEM-stage request/response protocol (optional MEM_RESP_CYCLE_CTR_EN counter).
// Latency: response_enable pulses exactly LATENCY cycles after an accepted rising edge of request_enable.
// Backpressure: one request at a time; edges seen while busy are dropped, busy flags the window.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] CTR_ADDR = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        request_enable,
  input  logic        mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        response_enable,
  output logic [31:0] data,
  output logic        busy
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  resp_state_e state;
  data_src_e   src_q;
  logic        req_q;
  logic [3:0]  cnt;
  logic        mode_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] ctr_snap_q;
  logic [31:0] ctr_now;
  logic [31:0] ram_rdata;
  logic [3:0]  ram_we;
  logic        ram_re;
  logic        accept;
  logic        enter_resp;
  logic [31:0] rd_addr;
  logic        rd_mode;

`ifdef MEM_RESP_CYCLE_CTR_EN
  localparam bit CTR_EN = 1'b1;
  logic [31:0] ctr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ctr_q <= '0;
    else       ctr_q <= ctr_q + 32'd1;
  end

  // Value the counter will hold during the RESP cycle being entered.
  assign ctr_now = ctr_q + 32'd1;
`else
  localparam bit CTR_EN = 1'b0;
  assign ctr_now = '0;
`endif

  function automatic logic in_range(input logic [31:0] a);
    return (a >> (ADDR_W + 2)) == 32'd0;
  endfunction

  function automatic logic ctr_hit(input logic [31:0] a);
    return CTR_EN && (a[31:2] == CTR_ADDR[31:2]);
  endfunction

  assign accept     = (state == ST_IDLE) && request_enable && !req_q;
  assign enter_resp = (accept && (LATENCY == 1)) || ((state == ST_BUSY) && (cnt == 4'd1));

  // With LATENCY=1 the read is issued on the accepting edge, before the capture registers load.
  assign rd_addr = (state == ST_IDLE) ? addr : addr_q;
  assign rd_mode = (state == ST_IDLE) ? mode : mode_q;
  assign ram_re  = enter_resp && (rd_mode == MEMREQ_READ) && in_range(rd_addr) && !ctr_hit(rd_addr);

  assign ram_we = ((state == ST_RESP) && (mode_q == MEMREQ_WRITE) && in_range(addr_q) && !ctr_hit(addr_q))
                  ? wstrb_q : 4'b0000;

  mem_bram_lanes #(.ADDR_W(ADDR_W)) u_lanes (
    .clk   (clk),
    .we    (ram_we),
    .waddr (addr_q[ADDR_W+1:2]),
    .wdata (wdata_q),
    .re    (ram_re),
    .raddr (rd_addr[ADDR_W+1:2]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= ST_IDLE;
      req_q           <= 1'b0;
      cnt             <= '0;
      response_enable <= 1'b0;
      busy            <= 1'b0;
      mode_q          <= MEMREQ_READ;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      src_q           <= SRC_ZERO;
      ctr_snap_q      <= '0;
    end else begin
      req_q           <= request_enable;
      response_enable <= 1'b0;

      // Source select only moves on a read response, so data holds between reads.
      if (enter_resp && (rd_mode == MEMREQ_READ)) begin
        if (ctr_hit(rd_addr))       src_q <= SRC_CTR;
        else if (in_range(rd_addr)) src_q <= SRC_RAM;
        else                        src_q <= SRC_ZERO;
        ctr_snap_q <= ctr_now;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            mode_q  <= mode;
            addr_q  <= addr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            busy    <= 1'b1;
            if (LATENCY == 1) begin
              state           <= ST_RESP;
              response_enable <= 1'b1;
            end else begin
              state <= ST_BUSY;
              cnt   <= LAT_M1;
            end
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd1) begin
            state           <= ST_RESP;
            response_enable <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data = '0;
    case (src_q)
      SRC_RAM: data = ram_rdata;
      SRC_CTR: data = ctr_snap_q;
      default: data = '0;
    endcase
  end

endmodule
